mmio_bridge: RTL and testbench
==============================

// Module: mmio_bridge
// PURPOSE
//  Parametrised memory-mapped I/O bridge between the cpu memory interface (mem_cmd/mem_addr)
//  and the on-chip RAM plus NUM_IN input ports (switches etc.) and NUM_OUT output registers (LEDs, HEX).
//  Replaces ad-hoc top-level decode gates; adds input synchronisers, sticky change flags,
//  an access-error pulse, and a uniform 1-cycle read latency for RAM and I/O.
// PARAMETERS
//  ADDR_W    9        cpu address width; bit ADDR_W-1 = 0 selects RAM, 1 selects I/O
//  DATA_W    16       data word width
//  NUM_IN    2        input ports, 1..8
//  NUM_OUT   2        output registers, 1..8
//  OUT_RST   0        reset value of every output register (DATA_W bits)
// PORTS
//  clk          in   1                 rising-edge clock
//  reset        in   1                 synchronous, active-high
//  mem_cmd      in   2                 00 MNONE, 01 MWRITE, 10 MREAD; 11 treated as MNONE
//  mem_addr     in   ADDR_W            cpu address
//  write_data   in   DATA_W            cpu write data
//  read_data    out  DATA_W            read data, valid when rd_valid=1
//  rd_valid     out  1                 one-cycle pulse, cycle after an MREAD
//  access_err   out  1                 one-cycle pulse, cycle after an illegal I/O access
//  ram_addr     out  ADDR_W-1          RAM read/write address = mem_addr[ADDR_W-2:0]
//  ram_write    out  1                 RAM write enable
//  ram_din      out  DATA_W            = write_data
//  ram_dout     in   DATA_W            RAM registered read data (1-cycle latency)
//  in_port      in   NUM_IN*DATA_W     async inputs; port k = bits [k*DATA_W +: DATA_W]
//  out_port     out  NUM_OUT*DATA_W    output registers, same packing
// BEHAVIOUR
//  - I/O map, offset o = mem_addr[ADDR_W-2:0] when mem_addr[ADDR_W-1]=1:
//    o<NUM_IN: input port o (RO); NUM_IN<=o<NUM_IN+NUM_OUT: out reg (RW);
//    o=NUM_IN+NUM_OUT: STATUS (RO, bit k = sticky change flag of input k, upper bits 0); else unmapped.
//  - Inputs pass through 2-flop synchronisers; reads return the second-stage value.
//    Change flag k sets when stage2 differs from its previous-cycle value; it clears on a STATUS read.
//    A set event in the same cycle as a STATUS read wins: read returns the old flags, and the new flag stays set.
//  - ram_write = (mem_cmd==01) & ~mem_addr[ADDR_W-1]; combinational. RAM reads are issued every cycle
//    on ram_addr.
//  - Out reg write: MWRITE to an out-reg offset loads write_data at that clock edge.
//    The new value appears on out_port the next cycle. A readback in the following cycle returns the new value.
//  - Read: MREAD in cycle N -> rd_valid=1 and read_data valid in N+1. The source selection is registered
//    (sel_ram_q): read_data = sel_ram_q ? ram_dout : io_rdata_q. io_rdata_q and sel_ram_q hold when no read occurs.
//  - Illegal access produces access_err=1 in N+1 and no state change. Illegal accesses are:
//    MREAD to an unmapped offset (read_data=0); MWRITE to an input, STATUS or unmapped offset.
//    RAM accesses never raise access_err.
//  - Back-to-back MREAD every cycle is supported at full throughput. Alternating RAM and I/O reads
//    return correct data in order.
//  - Reset values: out_port=OUT_RST per reg; synchronisers, change flags, io_rdata_q=0; sel_ram_q=0;
//    rd_valid=0; access_err=0. Reset overrides any same-cycle access; an in-flight read yields no rd_valid.
//  - ram_write=0 during reset.
// TESTING
//  1 Reset, NUM_IN=2, NUM_OUT=2: MWRITE 0x100+2 data 0x00A5 -> out_port[15:0]=0x00A5 next cycle;
//    MREAD 0x102 -> rd_valid, read_data=0x00A5.
//  2 RAM: MWRITE 0x010 data 0x1234 -> ram_write=1, ram_addr=0x10; next cycle MREAD 0x010 -> read_data=0x1234
//    one cycle later.
//  3 in_port[15:0] changes 0->0x0055 -> after 2 clocks MREAD 0x100 returns 0x0055; MREAD 0x104 returns 0x0001;
//    a second MREAD 0x104 returns 0x0000.
//  4 MWRITE 0x100 data 0xFFFF -> access_err pulse, input port unchanged. MREAD 0x1F0 -> access_err,
//    read_data=0, rd_valid=1.
//  5 Back-to-back MREAD 0x010, 0x102, 0x011 -> three consecutive rd_valid cycles with RAM, out reg 0,
//    RAM data in order.
//  6 Assert reset in the cycle after an MWRITE to 0x103 -> out_port returns to OUT_RST; rd_valid stays 0.

Source files
------------

// File: rtl/mmio_bridge_if.sv
// CPU-side memory bus between the processor and the MMIO bridge.
// The master drives commands and the slave returns read data and status pulses.
interface mmio_bridge_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              access_err;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, rd_valid, access_err
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, rd_valid, access_err
    );
endinterface

// File: rtl/mmio_bridge.sv
// Decodes CPU accesses to either the on-chip RAM or the I/O window.
// The I/O window holds synchronised inputs, output registers and a sticky change-status word.
module mmio_bridge #(
    parameter int unsigned       ADDR_W  = 9,
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       NUM_IN  = 2,
    parameter int unsigned       NUM_OUT = 2,
    parameter logic [DATA_W-1:0] OUT_RST = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    mmio_bridge_if.slave              bus,
    output logic [ADDR_W-2:0]         ram_addr,
    output logic                      ram_write,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout,
    input  logic [NUM_IN*DATA_W-1:0]  in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port
);
    localparam int unsigned OW = ADDR_W - 1;
    localparam logic [OW-1:0] IN_LIM  = OW'(NUM_IN);
    localparam logic [OW-1:0] OUT_LIM = OW'(NUM_IN + NUM_OUT);

    logic [NUM_IN*DATA_W-1:0]  sync1_q, sync2_q, prev_q;
    logic [NUM_IN-1:0]         flags_q, flags_d, chg;
    logic [NUM_OUT*DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0]         io_rdata_q, io_rdata_d, status;
    logic                      sel_ram_q, sel_ram_d;
    logic                      rd_valid_q, access_err_q, access_err_d;

    logic [OW-1:0] off;
    logic          io_sel, is_rd, is_wr, rd_io, wr_io;
    logic          is_in, is_out, is_stat;

    assign off    = bus.mem_addr[ADDR_W-2:0];
    assign io_sel = bus.mem_addr[ADDR_W-1];
    assign is_rd  = (bus.mem_cmd == 2'b10);
    assign is_wr  = (bus.mem_cmd == 2'b01);
    assign rd_io  = is_rd & io_sel;
    assign wr_io  = is_wr & io_sel;

    assign is_in   = (off < IN_LIM);
    assign is_out  = (off >= IN_LIM) && (off < OUT_LIM);
    assign is_stat = (off == OUT_LIM);

    assign ram_addr  = off;
    assign ram_din   = bus.write_data;
    assign ram_write = is_wr & ~io_sel & ~reset;

    assign out_port       = out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.access_err = access_err_q;
    assign bus.read_data  = sel_ram_q ? ram_dout : io_rdata_q;

    always_comb begin
        status = '0;
        status[NUM_IN-1:0] = flags_q;
        chg = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            chg[k] = |(sync2_q[k*DATA_W +: DATA_W] ^ prev_q[k*DATA_W +: DATA_W]);
        end
        // A change event in the same cycle as a STATUS read survives the clear.
        flags_d = ((rd_io && is_stat) ? '0 : flags_q) | chg;
    end

    always_comb begin
        out_d = out_q;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (wr_io && (off == OW'(NUM_IN + k))) begin
                out_d[k*DATA_W +: DATA_W] = bus.write_data;
            end
        end
    end

    always_comb begin
        io_rdata_d = io_rdata_q;
        if (rd_io) begin
            io_rdata_d = '0;
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (off == OW'(k)) io_rdata_d = sync2_q[k*DATA_W +: DATA_W];
            end
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                if (off == OW'(NUM_IN + k)) io_rdata_d = out_q[k*DATA_W +: DATA_W];
            end
            if (is_stat) io_rdata_d = status;
        end
        sel_ram_d    = is_rd ? ~io_sel : sel_ram_q;
        access_err_d = (rd_io && !(is_in || is_out || is_stat)) || (wr_io && !is_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            flags_q      <= '0;
            out_q        <= {NUM_OUT{OUT_RST}};
            io_rdata_q   <= '0;
            sel_ram_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            flags_q      <= flags_d;
            out_q        <= out_d;
            io_rdata_q   <= io_rdata_d;
            sel_ram_q    <= sel_ram_d;
            rd_valid_q   <= is_rd;
            access_err_q <= access_err_d;
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: responses expected per access are queued,
// and a monitor compares them whenever the bridge signals rd_valid or access_err.
module tb_mmio_bridge;
    localparam logic [1:0] MNONE = 2'b00, MWRITE = 2'b01, MREAD = 2'b10;

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic [15:0] mem [0:255];

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    mmio_bridge_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    mmio_bridge #(
        .ADDR_W (9),
        .DATA_W (16),
        .NUM_IN (2),
        .NUM_OUT(2),
        .OUT_RST(16'h0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_write(ram_write),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .in_port  (in_port),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic expect_resp(input logic rd, input logic [15:0] data, input logic err);
        exp_t e;
        e.rd = rd; e.data = data; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic op(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        bus.mem_cmd    = c;
        bus.mem_addr   = a;
        bus.write_data = d;
        @(posedge clk); #1;
        bus.mem_cmd = MNONE;
    endtask

    // Monitor: every response cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1 || bus.access_err === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rd_valid=%0b access_err=%0b expected none",
                             bus.rd_valid, bus.access_err);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_rd_valid", {31'd0, bus.rd_valid}, {31'd0, e.rd});
                    chk("resp_access_err", {31'd0, bus.access_err}, {31'd0, e.err});
                    if (e.rd) chk("resp_read_data", {16'd0, bus.read_data}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        in_port        = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.mem_cmd    = MWRITE;
        bus.mem_addr   = 9'h010;
        bus.write_data = 16'hDEAD;
        #1;
        chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
        chk("rst_out_port", out_port, 32'h0000_0000);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.mem_cmd = MNONE;

        // Output register 0 write and readback
        op(MWRITE, 9'h102, 16'h00A5);
        chk("out0_after_wr", out_port, 32'h0000_00A5);
        expect_resp(1'b1, 16'h00A5, 1'b0);
        op(MREAD, 9'h102, 16'h0);

        // RAM write with combinational strobe, then readback
        bus.mem_cmd    = MWRITE;
        bus.mem_addr   = 9'h010;
        bus.write_data = 16'h1234;
        #1;
        chk("ram_write", {31'd0, ram_write}, 32'd1);
        chk("ram_addr", {24'd0, ram_addr}, 32'h10);
        chk("ram_din", {16'd0, ram_din}, 32'h1234);
        @(posedge clk); #1;
        bus.mem_cmd = MNONE;
        expect_resp(1'b1, 16'h1234, 1'b0);
        op(MREAD, 9'h010, 16'h0);

        // Input sync and sticky change flag
        in_port[15:0] = 16'h0055;
        repeat (2) @(posedge clk);
        #1;
        expect_resp(1'b1, 16'h0055, 1'b0);
        op(MREAD, 9'h100, 16'h0);
        expect_resp(1'b1, 16'h0001, 1'b0);
        op(MREAD, 9'h104, 16'h0);
        expect_resp(1'b1, 16'h0000, 1'b0);
        op(MREAD, 9'h104, 16'h0);

        // Illegal accesses
        expect_resp(1'b0, 16'h0000, 1'b1);
        op(MWRITE, 9'h100, 16'hFFFF);
        expect_resp(1'b1, 16'h0055, 1'b0);
        op(MREAD, 9'h100, 16'h0);
        expect_resp(1'b1, 16'h0000, 1'b1);
        op(MREAD, 9'h1F0, 16'h0);
        expect_resp(1'b0, 16'h0000, 1'b1);
        op(MWRITE, 9'h104, 16'h00FF);
        expect_resp(1'b1, 16'h0000, 1'b0);
        op(MREAD, 9'h104, 16'h0);
        chk("out_after_illegal", out_port, 32'h0000_00A5);

        // Command 11 is a no-op and never strobes the RAM
        bus.mem_cmd  = 2'b11;
        bus.mem_addr = 9'h020;
        #1;
        chk("cmd11_ram_write", {31'd0, ram_write}, 32'd0);
        @(posedge clk); #1;
        bus.mem_cmd = MNONE;

        // Output register 1 readback in the following cycle
        op(MWRITE, 9'h103, 16'h1111);
        chk("out1_after_wr", out_port, 32'h1111_00A5);
        expect_resp(1'b1, 16'h1111, 1'b0);
        op(MREAD, 9'h103, 16'h0);

        // Back-to-back reads alternating RAM and I/O
        op(MWRITE, 9'h011, 16'h5678);
        expect_resp(1'b1, 16'h1234, 1'b0);
        op(MREAD, 9'h010, 16'h0);
        expect_resp(1'b1, 16'h00A5, 1'b0);
        op(MREAD, 9'h102, 16'h0);
        expect_resp(1'b1, 16'h5678, 1'b0);
        op(MREAD, 9'h011, 16'h0);

        // Change event coinciding with a STATUS read
        in_port[31:16] = 16'h0003;
        repeat (2) @(posedge clk);
        #1;
        expect_resp(1'b1, 16'h0000, 1'b0);
        op(MREAD, 9'h104, 16'h0);
        expect_resp(1'b1, 16'h0002, 1'b0);
        op(MREAD, 9'h104, 16'h0);
        expect_resp(1'b1, 16'h0003, 1'b0);
        op(MREAD, 9'h101, 16'h0);

        // Reset right after an out-reg write; the read issued during reset is dropped
        op(MWRITE, 9'h103, 16'hBEEF);
        chk("out1_before_rst", out_port, 32'hBEEF_00A5);
        reset = 1'b1;
        op(MREAD, 9'h103, 16'h0);
        reset = 1'b0;
        chk("out_after_rst", out_port, 32'h0000_0000);
        @(negedge clk);
        chk("rd_valid_after_rst", {31'd0, bus.rd_valid}, 32'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
